// File: rtl/gecko_pkg.sv
// Shared gecko core types: register address, in-flight status tag and default tag width.
// Also used by gecko_writeback so both ends of the writeback stream agree on tag width.
package gecko_pkg;

  localparam int STATUS_WIDTH_DEFAULT = 2;
  localparam int REG_ADDR_WIDTH       = 5;
  localparam int NUM_REGS             = 32;
  localparam int XLEN                 = 32;

  typedef logic [REG_ADDR_WIDTH-1:0]       reg_addr_t;
  typedef logic [STATUS_WIDTH_DEFAULT-1:0] reg_status_t;

  function automatic logic is_x0(input reg_addr_t addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/gecko_regfile_status.sv
// Per-register issue/retire counters: the youngest-producer tags, the full check for
// reservations and the pending flags for both read ports.
module gecko_regfile_status
  import gecko_pkg::*;
#(
  parameter int STATUS_WIDTH = STATUS_WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    reserve_fire,
  input  reg_addr_t               reserve_addr,
  input  logic                    retire_fire,
  input  reg_addr_t               retire_addr,
  input  reg_addr_t               rs1_addr,
  input  reg_addr_t               rs2_addr,
  output logic [STATUS_WIDTH-1:0] reserve_issue,
  output logic [STATUS_WIDTH-1:0] retire_issue,
  output logic                    reserve_full,
  output logic                    rs1_pending,
  output logic                    rs2_pending
);

  logic [STATUS_WIDTH-1:0] issue  [NUM_REGS];
  logic [STATUS_WIDTH-1:0] retire [NUM_REGS];
  logic [STATUS_WIDTH-1:0] in_flight;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        issue[i]  <= '0;
        retire[i] <= '0;
      end
    end else begin
      if (reserve_fire) issue[reserve_addr] <= issue[reserve_addr] + 1'b1;
      if (retire_fire)  retire[retire_addr] <= retire[retire_addr] + 1'b1;
    end
  end

  // All-ones in-flight count is the limit: one more would alias a zero difference.
  assign in_flight     = issue[reserve_addr] - retire[reserve_addr];
  assign reserve_full  = &in_flight;
  assign reserve_issue = issue[reserve_addr];
  assign retire_issue  = issue[retire_addr];

  assign rs1_pending = !is_x0(rs1_addr) && (issue[rs1_addr] != retire[rs1_addr]);
  assign rs2_pending = !is_x0(rs2_addr) && (issue[rs2_addr] != retire[rs2_addr]);

endmodule

// File: rtl/gecko_regfile.sv
// Gecko integer register file with in-flight tags; only the youngest producer commits.
// Optional GECKO_REGFILE_BYPASS_EN forwards an enabled writeback to the read ports same cycle.
module gecko_regfile
  import gecko_pkg::*;
#(
  parameter int STATUS_WIDTH = STATUS_WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    reserve_valid,
  input  reg_addr_t               reserve_addr,
  output logic                    reserve_ready,
  output logic [STATUS_WIDTH-1:0] reserve_status,
  input  logic                    writeback_valid,
  output logic                    writeback_ready,
  input  reg_addr_t               writeback_addr,
  input  logic [XLEN-1:0]         writeback_value,
  input  logic [STATUS_WIDTH-1:0] writeback_reg_status,
  input  reg_addr_t               rs1_addr,
  input  reg_addr_t               rs2_addr,
  output logic [XLEN-1:0]         rs1_data,
  output logic [XLEN-1:0]         rs2_data,
  output logic                    rs1_pending,
  output logic                    rs2_pending
);

  logic [XLEN-1:0]         regs [NUM_REGS];
  logic [STATUS_WIDTH-1:0] reserve_issue;
  logic [STATUS_WIDTH-1:0] retire_issue;
  logic                    reserve_full;
  logic                    reserve_fire;
  logic                    writeback_fire;
  logic                    write_en;

  gecko_regfile_status #(
    .STATUS_WIDTH(STATUS_WIDTH)
  ) u_status (
    .clk          (clk),
    .rst          (rst),
    .reserve_fire (reserve_fire),
    .reserve_addr (reserve_addr),
    .retire_fire  (writeback_fire),
    .retire_addr  (writeback_addr),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .reserve_issue(reserve_issue),
    .retire_issue (retire_issue),
    .reserve_full (reserve_full),
    .rs1_pending  (rs1_pending),
    .rs2_pending  (rs2_pending)
  );

  // x0 is always grantable and never touches the counters.
  assign reserve_ready   = rst && (is_x0(reserve_addr) || !reserve_full);
  assign reserve_status  = is_x0(reserve_addr) ? '0 : reserve_issue + 1'b1;
  assign writeback_ready = rst;

  assign reserve_fire   = reserve_valid && reserve_ready && !is_x0(reserve_addr);
  assign writeback_fire = writeback_valid && writeback_ready && !is_x0(writeback_addr);
  // Compare against the pre-increment issue count so a stale producer retires silently.
  assign write_en       = writeback_fire && (writeback_reg_status == retire_issue);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (write_en) begin
      regs[writeback_addr] <= writeback_value;
    end
  end

  always_comb begin
    rs1_data = is_x0(rs1_addr) ? '0 : regs[rs1_addr];
    rs2_data = is_x0(rs2_addr) ? '0 : regs[rs2_addr];
`ifdef GECKO_REGFILE_BYPASS_EN
    if (write_en && (writeback_addr == rs1_addr)) rs1_data = writeback_value;
    if (write_en && (writeback_addr == rs2_addr)) rs2_data = writeback_value;
`endif
  end

endmodule

// File: tb/tb_gecko_regfile.sv
// Scoreboard bench for gecko_regfile: expectations are queued as stimulus is applied
// and drained against the DUT outputs shortly after each cycle's inputs settle.
module tb_gecko_regfile;
  import gecko_pkg::*;

  localparam int SW = 2;

  localparam int K_RS1_DATA = 0;
  localparam int K_RS1_PEND = 1;
  localparam int K_RS2_DATA = 2;
  localparam int K_RS2_PEND = 3;
  localparam int K_RSV_RDY  = 4;
  localparam int K_RSV_TAG  = 5;
  localparam int K_WB_RDY   = 6;

  logic            clk;
  logic            rst;
  logic            reserve_valid;
  reg_addr_t       reserve_addr;
  logic            reserve_ready;
  logic [SW-1:0]   reserve_status;
  logic            writeback_valid;
  logic            writeback_ready;
  reg_addr_t       writeback_addr;
  logic [31:0]     writeback_value;
  logic [SW-1:0]   writeback_reg_status;
  reg_addr_t       rs1_addr;
  reg_addr_t       rs2_addr;
  logic [31:0]     rs1_data;
  logic [31:0]     rs2_data;
  logic            rs1_pending;
  logic            rs2_pending;

  int n_checks = 0;
  int n_fail   = 0;

  int          q_kind[$];
  logic [31:0] q_exp[$];
  string       q_tag[$];

  gecko_regfile #(.STATUS_WIDTH(SW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .reserve_valid       (reserve_valid),
    .reserve_addr        (reserve_addr),
    .reserve_ready       (reserve_ready),
    .reserve_status      (reserve_status),
    .writeback_valid     (writeback_valid),
    .writeback_ready     (writeback_ready),
    .writeback_addr      (writeback_addr),
    .writeback_value     (writeback_value),
    .writeback_reg_status(writeback_reg_status),
    .rs1_addr            (rs1_addr),
    .rs2_addr            (rs2_addr),
    .rs1_data            (rs1_data),
    .rs2_data            (rs2_data),
    .rs1_pending         (rs1_pending),
    .rs2_pending         (rs2_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_RS1_DATA: return rs1_data;
      K_RS1_PEND: return {31'd0, rs1_pending};
      K_RS2_DATA: return rs2_data;
      K_RS2_PEND: return {31'd0, rs2_pending};
      K_RSV_RDY:  return {31'd0, reserve_ready};
      K_RSV_TAG:  return {30'd0, reserve_status};
      K_WB_RDY:   return {31'd0, writeback_ready};
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_out(input int kind, input logic [31:0] exp, input string tag);
    q_kind.push_back(kind);
    q_exp.push_back(exp);
    q_tag.push_back(tag);
  endtask

  task automatic check_now();
    int k;
    logic [31:0] e;
    string t;
    #1;
    while (q_kind.size() > 0) begin
      k = q_kind.pop_front();
      e = q_exp.pop_front();
      t = q_tag.pop_front();
      check(t, observe(k), e);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    reserve_valid   = 1'b0;
    writeback_valid = 1'b0;
  endtask

  task automatic do_reserve(input reg_addr_t a);
    reserve_valid = 1'b1;
    reserve_addr  = a;
  endtask

  task automatic do_writeback(input reg_addr_t a, input logic [SW-1:0] tag, input logic [31:0] v);
    writeback_valid      = 1'b1;
    writeback_addr       = a;
    writeback_reg_status = tag;
    writeback_value      = v;
  endtask

  logic [31:0] bypass_x9;

  initial begin
    rst = 1'b0;
    reserve_valid = 1'b0; reserve_addr = '0;
    writeback_valid = 1'b0; writeback_addr = '0;
    writeback_value = '0; writeback_reg_status = '0;
    rs1_addr = '0; rs2_addr = '0;

    // Reset state, with a reservation attempt held during reset.
    next_cycle();
    next_cycle();
    do_reserve(5'd5);
    rs1_addr = 5'd5;
    expect_out(K_RSV_RDY, 0, "reset_reserve_ready");
    expect_out(K_WB_RDY,  0, "reset_writeback_ready");
    expect_out(K_RS1_DATA, 0, "reset_rs1_data");
    expect_out(K_RS1_PEND, 0, "reset_rs1_pending");
    check_now();
    next_cycle();
    rst = 1'b1;

    // Basic reserve / writeback on x5.
    next_cycle();
    do_reserve(5'd5);
    rs1_addr = 5'd5;
    expect_out(K_RSV_RDY, 1, "x5_reserve_ready");
    expect_out(K_RSV_TAG, 1, "x5_reserve_tag");
    expect_out(K_WB_RDY,  1, "writeback_ready_out_of_reset");
    expect_out(K_RS1_PEND, 0, "x5_pending_before");
    check_now();
    next_cycle();
    expect_out(K_RS1_PEND, 1, "x5_pending_after_reserve");
    check_now();
    next_cycle();
    do_writeback(5'd5, 2'd1, 32'hAABB_CCDD);
`ifdef GECKO_REGFILE_BYPASS_EN
    expect_out(K_RS1_DATA, 32'hAABB_CCDD, "x5_bypass_data");
`else
    expect_out(K_RS1_DATA, 0, "x5_data_not_yet_visible");
`endif
    check_now();
    next_cycle();
    expect_out(K_RS1_DATA, 32'hAABB_CCDD, "x5_data");
    expect_out(K_RS1_PEND, 0, "x5_pending_cleared");
    check_now();

    // Out-of-order retirement on x7: only the youngest tag commits.
    next_cycle();
    do_reserve(5'd7);
    rs1_addr = 5'd7;
    expect_out(K_RSV_TAG, 1, "x7_tag1");
    check_now();
    next_cycle();
    do_reserve(5'd7);
    expect_out(K_RSV_TAG, 2, "x7_tag2");
    check_now();
    next_cycle();
    do_writeback(5'd7, 2'd2, 32'h42);
    check_now();
    next_cycle();
    do_writeback(5'd7, 2'd1, 32'h99);
    expect_out(K_RS1_DATA, 32'h42, "x7_young_value");
    expect_out(K_RS1_PEND, 1, "x7_still_pending");
    check_now();
    next_cycle();
    expect_out(K_RS1_DATA, 32'h42, "x7_stale_not_written");
    expect_out(K_RS1_PEND, 0, "x7_pending_cleared");
    check_now();

    // Counter full and wrap-around on x3.
    rs1_addr = 5'd3;
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      do_reserve(5'd3);
      expect_out(K_RSV_RDY, 1, $sformatf("x3_ready_%0d", i));
      expect_out(K_RSV_TAG, i, $sformatf("x3_tag_%0d", i));
      check_now();
    end
    next_cycle();
    do_reserve(5'd3);
    expect_out(K_RSV_RDY, 0, "x3_full_blocked");
    check_now();
    next_cycle();
    expect_out(K_RS1_PEND, 1, "x3_pending_while_full");
    do_writeback(5'd3, 2'd1, 32'h1111_1111);
    check_now();
    next_cycle();
    do_reserve(5'd3);
    expect_out(K_RSV_RDY, 1, "x3_ready_after_retire");
    expect_out(K_RSV_TAG, 0, "x3_wrap_tag");
    expect_out(K_RS1_DATA, 0, "x3_stale_not_written");
    check_now();
    next_cycle();
    do_reserve(5'd3);
    expect_out(K_RSV_RDY, 0, "x3_full_again");
    check_now();

    // x0 is immune to reserve and writeback.
    next_cycle();
    do_reserve(5'd0);
    do_writeback(5'd0, 2'd0, 32'h1F);
    rs2_addr = 5'd0;
    expect_out(K_RSV_RDY, 1, "x0_ready");
    expect_out(K_RSV_TAG, 0, "x0_tag");
    expect_out(K_RS2_DATA, 0, "x0_data_same_cycle");
    expect_out(K_RS2_PEND, 0, "x0_pending");
    check_now();
    next_cycle();
    expect_out(K_RS2_DATA, 0, "x0_data_after");
    expect_out(K_RS2_PEND, 0, "x0_pending_after");
    check_now();

    // Same-cycle reserve and writeback on x9.
    next_cycle();
    do_reserve(5'd9);
    rs1_addr = 5'd9;
    rs2_addr = 5'd9;
    expect_out(K_RSV_TAG, 1, "x9_tag1");
    check_now();
    next_cycle();
    do_reserve(5'd9);
    do_writeback(5'd9, 2'd1, 32'h1234_5678);
`ifdef GECKO_REGFILE_BYPASS_EN
    bypass_x9 = 32'h1234_5678;
`else
    bypass_x9 = 32'h0;
`endif
    expect_out(K_RSV_TAG, 2, "x9_tag2_same_cycle");
    expect_out(K_RS1_DATA, bypass_x9, "x9_same_cycle_data");
    check_now();
    next_cycle();
    expect_out(K_RS1_DATA, 32'h1234_5678, "x9_value_written");
    expect_out(K_RS2_PEND, 1, "x9_pending_issue2_retire1");
    check_now();
    next_cycle();
    do_reserve(5'd9);
    expect_out(K_RSV_TAG, 3, "x9_issue_is_2");
    check_now();

    // Reset mid-stream after writing x4.
    next_cycle();
    do_reserve(5'd4);
    rs1_addr = 5'd4;
    check_now();
    next_cycle();
    do_writeback(5'd4, 2'd1, 32'h42);
    check_now();
    next_cycle();
    expect_out(K_RS1_DATA, 32'h42, "x4_written");
    do_reserve(5'd4);
    check_now();
    next_cycle();
    rst = 1'b0;
    do_reserve(5'd4);
    do_writeback(5'd4, 2'd2, 32'h77);
    expect_out(K_RSV_RDY, 0, "midreset_reserve_ready");
    expect_out(K_WB_RDY,  0, "midreset_writeback_ready");
    check_now();
    next_cycle();
    rst = 1'b1;
    rs2_addr = 5'd9;
    expect_out(K_RS1_DATA, 0, "x4_cleared");
    expect_out(K_RS1_PEND, 0, "x4_pending_cleared");
    expect_out(K_RS2_PEND, 0, "x9_pending_cleared");
    check_now();
    next_cycle();
    do_reserve(5'd4);
    expect_out(K_RSV_TAG, 1, "x4_first_tag_after_reset");
    check_now();
    next_cycle();

    if (q_kind.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", q_kind.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gecko_regfile.md
GECKO_REGFILE -- requirements
Module: gecko_regfile

Interface
REQ-001 SHALL have parameter STATUS_WIDTH, default 2, meaning the width of the per-register in-flight status counter.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-low; state is reset on a clk edge while rst is 0.
REQ-004 SHALL have port reserve_valid  input  1  decode requests a destination register for a new instruction.
REQ-005 SHALL have port reserve_addr  input  5  destination register index.
REQ-006 SHALL have port reserve_ready  output  1  the reservation is accepted this cycle.
REQ-007 SHALL have port reserve_status  output  STATUS_WIDTH  status tag given to the instruction; valid while reserve_valid is 1 and reserve_ready is 1.
REQ-008 SHALL have port writeback_valid  input  1  the writeback_result stream from gecko_writeback.
REQ-009 SHALL have port writeback_ready  output  1  stream ready.
REQ-010 SHALL have port writeback_addr  input  5  destination register index.
REQ-011 SHALL have port writeback_value  input  32  result data.
REQ-012 SHALL have port writeback_reg_status  input  STATUS_WIDTH  the producer's reserved tag.
REQ-013 SHALL have ports rs1_addr and rs2_addr  input  5 each  read indices.
REQ-014 SHALL have ports rs1_data and rs2_data  output  32 each  read data, combinational from the indices.
REQ-015 SHALL have ports rs1_pending and rs2_pending  output  1 each  the register has an unretired producer.

Function
REQ-016 SHALL hold per register a 32-bit value, an issue counter and a retire counter, each counter STATUS_WIDTH bits wide and wrapping modulo 2^STATUS_WIDTH.
REQ-017 SHALL drive reserve_status = issue[reserve_addr]+1 and increment issue[reserve_addr] on each reserve handshake.
REQ-018 SHALL drive reserve_ready low when issue-retire (mod 2^STATUS_WIDTH) equals 2^STATUS_WIDTH-1 for reserve_addr (counter full); this blocks the reservation with no state change.
REQ-019 SHALL tie writeback_ready to 1 (out of reset); every writeback handshake increments retire[writeback_addr].
REQ-020 SHALL write writeback_value to the register only when writeback_reg_status equals the pre-update issue[writeback_addr], so only the youngest producer commits; older results retire without writing.
REQ-021 SHALL drive rsN_pending = (issue != retire) for rsN_addr, using registered state only.
REQ-022 SHALL make a write visible on rsN_data on the cycle after the handshake.
REQ-023 SHALL treat x0 specially: reads return 0, pending is always 0, writes and retire updates are ignored, and a reservation of x0 is always ready with reserve_status = 0 and no counter change.
REQ-024 SHALL, on a reserve and a writeback to the same register in one cycle, apply both updates; the write-enable compare uses the pre-increment issue value.
REQ-025 SHALL hold no other state; the block has no internal state machine beyond the counters.

Reset
REQ-026 SHALL, while rst is 0, clear all values, issue counters and retire counters to 0 and drive reserve_ready=0 and writeback_ready=0.
REQ-027 SHALL discard any handshake in flight during a reset cycle; rsN_data reads 0 and rsN_pending reads 0 in the cycle after reset.

Configuration
REQ-028 SHALL, when GECKO_REGFILE_BYPASS_EN is defined, forward writeback_value to rsN_data in the same cycle when writeback_valid=1, the write is enabled (REQ-020), the addresses match and the address is not x0; without the macro, reads see registered state only (REQ-022).

Structure
REQ-029 SHALL place the STATUS_WIDTH default, the reg-status typedef and the register-address typedef in the gecko package, shared with gecko_writeback.
REQ-030 SHALL use one sub-module, gecko_regfile_status, holding the issue/retire counter array, the full check and the pending outputs.

Verification
REQ-031 Reserve x5 -> reserve_status=1; rs1_addr=5 gives rs1_pending=1; writeback x5 with status 1 and value 0xAABBCCDD -> next cycle rs1_data=0xAABBCCDD and rs1_pending=0.
REQ-032 Reserve x7 twice (tags 1 and 2), then write back tag 2 with value 0x42, then tag 1 with value 0x99 -> rs1_data=0x42; pending stays 1 until the second writeback, then 0.
REQ-033 With STATUS_WIDTH=2, reserve x3 three times -> the fourth attempt sees reserve_ready=0; one writeback -> the fourth attempt is accepted with tag 0 (wrap-around).
REQ-034 Reserve x0 and write back x0 with value 0x1F -> reserve_status=0, rs2_data=0, rs2_pending=0.
REQ-035 Same-cycle reserve and writeback of x9 with tag 1 -> value written, issue=2, retire=1, pending=1; with GECKO_REGFILE_BYPASS_EN defined, rs1_data shows the value in the same cycle.
REQ-036 Assert rst=0 mid-stream after writing x4=0x42 -> rs1_data=0 for x4, all pending=0, and the first reservation afterwards gets tag 1.
